// File: rtl/z80_bus_master.sv
// Z80 bus initiator: runs M1 fetch, memory and I/O cycles on the ULA strobe set,
// with T-states of DIV clk28 cycles and a req/ready/ack request port.
module z80_bus_master #(
    parameter int DIV = 8
) (
    input  logic        clk28,
    input  logic        rst,
    input  logic        req,
    output logic        req_ready,
    input  logic        req_m1,
    input  logic        req_io,
    input  logic        req_we,
    input  logic [15:0] req_addr,
    input  logic [7:0]  req_wdata,
    input  logic [7:0]  i_reg,
    output logic        ack,
    output logic [7:0]  rdata,
    output logic        clkcpu,
    output logic [15:0] a,
    output logic [7:0]  d_o,
    output logic        d_oe,
    input  logic [7:0]  d_i,
    input  logic        n_wait,
    output logic        n_mreq,
    output logic        n_iorq,
    output logic        n_rd,
    output logic        n_wr,
    output logic        n_m1,
    output logic        n_rfsh
);
    localparam int PW = $clog2(DIV);
    localparam logic [PW-1:0] PH_ZERO = '0;
    localparam logic [PW-1:0] PH_HALF = PW'(DIV / 2);
    localparam logic [PW-1:0] PH_LAST = PW'(DIV - 1);

    typedef enum logic [2:0] {IDLE, T1, T2, TW, T3, T4} state_t;

    state_t        state, state_n;
    logic [PW-1:0] ph, ph_n;
    logic          ph_last, pend, wait_s, acc, start;
    logic          c_m1, c_io, c_we;
    logic [15:0]   c_addr;
    logic [7:0]    c_wdata, c_ireg;
    logic [6:0]    r;
    logic          m1_n, io_n, we_n;
    logic [15:0]   addr_n;
    logic [7:0]    wdata_n;
    logic          t1a, t1h, mid, t3a, t3l, t3h, t4a, t4l;
    logic          mreq_lo, iorq_lo, rd_lo, wr_lo, m1_lo, rfsh_lo, oe_nx;

    assign ph_last   = (ph == PH_LAST);
    assign ph_n      = ph_last ? PH_ZERO : ph + PW'(1);
    assign ack       = ph_last && (state == T4 || (state == T3 && !c_m1));
    assign req_ready = (state == IDLE && !pend) || ack;
    assign acc       = req && req_ready;
    assign start     = pend || acc;

    // Request fields as they will be next cycle, so a back-to-back T1 sees the new request
    assign m1_n    = acc ? req_m1 : c_m1;
    assign io_n    = acc ? (req_io & ~req_m1) : c_io;
    assign we_n    = acc ? (req_we & ~req_m1) : c_we;
    assign addr_n  = acc ? req_addr : c_addr;
    assign wdata_n = acc ? req_wdata : c_wdata;

    always_comb begin
        state_n = state;
        if (ph_last) begin
            case (state)
                IDLE:    if (start) state_n = T1;
                T1:      state_n = T2;
                T2:      state_n = (c_io || wait_s) ? TW : T3;
                TW:      state_n = wait_s ? TW : T3;
                T3:      state_n = c_m1 ? T4 : (start ? T1 : IDLE);
                T4:      state_n = start ? T1 : IDLE;
                default: state_n = IDLE;
            endcase
        end
    end

    // Strobes are decoded from the next state/phase and registered, so each edge lands
    // exactly on its rise/fall clk28 cycle.
    always_comb begin
        t1a     = (state_n == T1);
        t1h     = t1a && (ph_n >= PH_HALF);
        mid     = (state_n == T2) || (state_n == TW);
        t3a     = (state_n == T3);
        t3l     = t3a && (ph_n < PH_HALF);
        t3h     = t3a && (ph_n >= PH_HALF);
        t4a     = (state_n == T4);
        t4l     = t4a && (ph_n < PH_HALF);
        mreq_lo = !io_n && (t1h || mid || (m1_n ? (t3h || t4l) : t3l));
        iorq_lo = io_n && (mid || t3l);
        rd_lo   = !we_n && (io_n ? (mid || t3l) : (t1h || mid || (!m1_n && t3l)));
        wr_lo   = we_n && (mid || t3l);
        m1_lo   = m1_n && (t1a || mid);
        rfsh_lo = m1_n && (t3a || t4a);
        oe_nx   = we_n && ((io_n ? t1a : t1h) || mid || t3a);
    end

    always_ff @(posedge clk28 or posedge rst) begin
        if (rst) begin
            state   <= IDLE;
            ph      <= PH_ZERO;
            clkcpu  <= 1'b1;
            pend    <= 1'b0;
            wait_s  <= 1'b0;
            c_m1    <= 1'b0;
            c_io    <= 1'b0;
            c_we    <= 1'b0;
            c_addr  <= '0;
            c_wdata <= '0;
            c_ireg  <= '0;
            r       <= '0;
            rdata   <= '0;
            a       <= '0;
            d_o     <= '0;
            d_oe    <= 1'b0;
            n_mreq  <= 1'b1;
            n_iorq  <= 1'b1;
            n_rd    <= 1'b1;
            n_wr    <= 1'b1;
            n_m1    <= 1'b1;
            n_rfsh  <= 1'b1;
        end else begin
            state  <= state_n;
            ph     <= ph_n;
            clkcpu <= (ph_n < PH_HALF);
            pend   <= ph_last ? 1'b0 : start;
            if (acc) begin
                c_m1    <= req_m1;
                c_io    <= req_io & ~req_m1;
                c_we    <= req_we & ~req_m1;
                c_addr  <= req_addr;
                c_wdata <= req_wdata;
                c_ireg  <= i_reg;
            end
            if ((state == T2 || state == TW) && ph == PH_HALF)
                wait_s <= !n_wait;
            if (state == T3 && c_m1 && ph == PH_ZERO)
                rdata <= d_i;
            else if (state == T3 && !c_m1 && !c_we && ph == PH_HALF)
                rdata <= d_i;
            if (state == T4 && ph_last)
                r <= r + 7'd1;
            if (t1a && ph_n == PH_ZERO)
                a <= addr_n;
            else if (m1_n && t3a && ph_n == PH_ZERO)
                a <= {c_ireg, 1'b0, r};
            if (we_n && t1a && ph_n == (io_n ? PH_ZERO : PH_HALF))
                d_o <= wdata_n;
            d_oe   <= oe_nx;
            n_mreq <= !mreq_lo;
            n_iorq <= !iorq_lo;
            n_rd   <= !rd_lo;
            n_wr   <= !wr_lo;
            n_m1   <= !m1_lo;
            n_rfsh <= !rfsh_lo;
        end
    end
endmodule

// File: tb/tb_z80_bus_master.sv
// Scoreboard bench for z80_bus_master: requests push expected results,
// a monitor pops and checks them on every ack.
module tb_z80_bus_master;
    localparam int DIV = 8;

    logic        clk28 = 1'b0, rst = 1'b1, req = 1'b0;
    logic        req_m1 = 1'b0, req_io = 1'b0, req_we = 1'b0;
    logic [15:0] req_addr = '0;
    logic [7:0]  req_wdata = '0, i_reg = '0, d_i = '0;
    logic        n_wait = 1'b1;
    logic        req_ready, ack, clkcpu, d_oe;
    logic [7:0]  rdata, d_o;
    logic [15:0] a;
    logic        n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh;

    z80_bus_master #(.DIV(DIV)) dut (
        .clk28(clk28), .rst(rst), .req(req), .req_ready(req_ready),
        .req_m1(req_m1), .req_io(req_io), .req_we(req_we),
        .req_addr(req_addr), .req_wdata(req_wdata), .i_reg(i_reg),
        .ack(ack), .rdata(rdata), .clkcpu(clkcpu), .a(a), .d_o(d_o),
        .d_oe(d_oe), .d_i(d_i), .n_wait(n_wait),
        .n_mreq(n_mreq), .n_iorq(n_iorq), .n_rd(n_rd), .n_wr(n_wr),
        .n_m1(n_m1), .n_rfsh(n_rfsh)
    );

    always #5 clk28 = ~clk28;

    typedef struct {
        string       name;
        bit          is_read;
        bit          chk_do;
        bit          b2b;
        logic [7:0]  rd;
        logic [15:0] addr;
        logic [7:0]  dout;
        int          len, acc_cyc;
        int          mreq, iorq, rdc, wrc, m1c, rfsh, doe;
    } exp_t;

    exp_t       sb[$];
    int         checks = 0, errors = 0, cyc = 0;
    logic [6:0] r_model = '0;

    always @(posedge clk28) cyc <= cyc + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp_v);
        checks++;
        if (act !== exp_v) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp_v);
        end
    endtask

    // Monitor: counts strobe-low cycles per transaction and checks everything at ack
    int   rise_q[$];
    int   last_ack = -100;
    logic prev_ck = 1'b1;
    int   c_mq = 0, c_io = 0, c_rd = 0, c_wr = 0, c_m1 = 0, c_rf = 0, c_oe = 0;
    always @(negedge clk28) begin
        if (rst) begin
            c_mq = 0; c_io = 0; c_rd = 0; c_wr = 0; c_m1 = 0; c_rf = 0; c_oe = 0;
            rise_q.delete();
            prev_ck = 1'b1;
        end else begin
            if (clkcpu && !prev_ck) rise_q.push_back(cyc);
            prev_ck = clkcpu;
            c_mq += int'(!n_mreq); c_io += int'(!n_iorq); c_rd += int'(!n_rd);
            c_wr += int'(!n_wr);   c_m1 += int'(!n_m1);   c_rf += int'(!n_rfsh);
            c_oe += int'(d_oe);
            if (ack) begin
                if (sb.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_ack: ack at cycle %0d, expected none", cyc);
                end else begin
                    exp_t e;
                    int st;
                    e = sb.pop_front();
                    while (rise_q.size() > 0 && rise_q[0] <= e.acc_cyc) void'(rise_q.pop_front());
                    st = (rise_q.size() > 0) ? rise_q[0] : -1;
                    chk({e.name, "_len"}, cyc - st + 1, e.len);
                    if (e.b2b) chk({e.name, "_t1_after_ack"}, st, last_ack + 1);
                    if (e.is_read) chk({e.name, "_rdata"}, rdata, e.rd);
                    chk({e.name, "_addr"}, a, e.addr);
                    if (e.chk_do) chk({e.name, "_d_o"}, d_o, e.dout);
                    chk({e.name, "_mreq_lo"}, c_mq, e.mreq);
                    chk({e.name, "_iorq_lo"}, c_io, e.iorq);
                    chk({e.name, "_rd_lo"}, c_rd, e.rdc);
                    chk({e.name, "_wr_lo"}, c_wr, e.wrc);
                    chk({e.name, "_m1_lo"}, c_m1, e.m1c);
                    chk({e.name, "_rfsh_lo"}, c_rf, e.rfsh);
                    chk({e.name, "_d_oe_hi"}, c_oe, e.doe);
                end
                last_ack = cyc;
                c_mq = 0; c_io = 0; c_rd = 0; c_wr = 0; c_m1 = 0; c_rf = 0; c_oe = 0;
            end
        end
    end

    // kind: 0 M1, 1 mem read, 2 mem write, 3 I/O read, 4 I/O write; w = extra TWs.
    // Called on a negedge; leaves req asserted and returns on the negedge after acceptance.
    task automatic issue(input string nm, input int kind, input logic [15:0] ad,
                         input logic [7:0] wd, input logic [7:0] erd, input int w,
                         input bit b2b, input bit push);
        exp_t e;
        int   n = 0;
        req_m1 = (kind == 0); req_io = (kind >= 3); req_we = (kind == 2 || kind == 4);
        req_addr = ad; req_wdata = wd; req = 1'b1;
        while (!req_ready && n < 400) begin @(negedge clk28); n++; end
        if (!req_ready) begin
            checks++; errors++;
            $display("FAIL %s_accept: req_ready 0 after %0d cycles, expected 1", nm, n);
            return;
        end
        e = '{name: nm, is_read: 0, chk_do: 0, b2b: b2b, rd: erd, addr: ad, dout: wd,
              len: 0, acc_cyc: cyc, mreq: 0, iorq: 0, rdc: 0, wrc: 0, m1c: 0, rfsh: 0, doe: 0};
        case (kind)
            0: begin
                e.is_read = 1; e.len = 32 + 8*w; e.mreq = 20 + 8*w; e.rdc = 12 + 8*w;
                e.m1c = 16 + 8*w; e.rfsh = 16; e.addr = {i_reg, 1'b0, r_model};
                if (push) r_model = r_model + 7'd1;
            end
            1: begin e.is_read = 1; e.len = 24 + 8*w; e.mreq = 16 + 8*w; e.rdc = 16 + 8*w; end
            2: begin
                e.chk_do = 1; e.len = 24 + 8*w; e.mreq = 16 + 8*w; e.wrc = 12 + 8*w;
                e.doe = 20 + 8*w;
            end
            3: begin e.is_read = 1; e.len = 32 + 8*w; e.iorq = 20 + 8*w; e.rdc = 20 + 8*w; end
            default: begin
                e.chk_do = 1; e.len = 32 + 8*w; e.iorq = 20 + 8*w; e.wrc = 20 + 8*w;
                e.doe = 32 + 8*w;
            end
        endcase
        if (push) sb.push_back(e);
        @(posedge clk28);
        @(negedge clk28);
    endtask

    task automatic wait_idle(input string nm);
        int n = 0;
        while (sb.size() != 0 && n < 2000) begin @(negedge clk28); n++; end
        if (sb.size() != 0) begin
            checks++; errors++;
            $display("FAIL %s_drain: %0d acks outstanding, expected 0", nm, sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clk28);
    endtask

    initial begin
        #1_000_000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        int   n;
        int   cnt;
        logic pk;
        repeat (3) @(negedge clk28);
        chk("rst_strobes", {n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh}, 6'h3F);
        chk("rst_d_oe", d_oe, 0);
        chk("rst_a", a, 16'h0000);
        chk("rst_d_o", d_o, 8'h00);
        chk("rst_rdata", rdata, 8'h00);
        chk("rst_ack", ack, 0);
        chk("rst_req_ready", req_ready, 1);
        rst = 1'b0;
        @(negedge clk28);

        // Abort a memory write in T2 with an asynchronous reset
        issue("abort", 2, 16'h4000, 8'hA5, 8'h00, 0, 0, 0);
        n = 0;
        while (n_wr !== 1'b0 && n < 100) begin @(negedge clk28); n++; end
        chk("abort_in_t2", n_wr, 0);
        req = 1'b0;
        #2 rst = 1'b1;
        #1;
        chk("abort_strobes", {n_mreq, n_iorq, n_rd, n_wr, n_m1, n_rfsh}, 6'h3F);
        chk("abort_d_oe", d_oe, 0);
        chk("abort_a", a, 16'h0000);
        chk("abort_ack", ack, 0);
        @(negedge clk28); @(negedge clk28);
        rst = 1'b0;
        chk("abort_ready", req_ready, 1);
        @(negedge clk28);

        // M1 fetches: five to bring R to 5, then 0x1234 (refresh 0x3F05), then 0x3F06
        i_reg = 8'h3F; d_i = 8'h3E;
        for (int i = 0; i < 5; i++) issue("m1_pre", 0, 16'h0100 + 16'(i), 8'h00, 8'h3E, 0, i > 0, 1);
        issue("m1", 0, 16'h1234, 8'h00, 8'h3E, 0, 1, 1);
        issue("m1_next", 0, 16'h1235, 8'h00, 8'h3E, 0, 1, 1);
        req = 1'b0;
        wait_idle("m1");

        // Refresh wrap: run R up to 0x7F, then 128 held M1s across the wrap
        for (int i = 0; i < 248; i++) issue("m1_wrap", 0, 16'h2000 + 16'(i), 8'h00, 8'h3E, 0, i > 0, 1);
        req = 1'b0;
        wait_idle("m1_wrap");

        // Memory write with n_wait low for two T2/TW samples
        issue("memwr", 2, 16'h4000, 8'hA5, 8'h00, 2, 0, 1);
        req = 1'b0;
        n_wait = 1'b0;
        cnt = 0; n = 0; pk = clkcpu;
        while (cnt < 2 && n < 200) begin
            @(negedge clk28); n++;
            if (!clkcpu && pk && !n_wr && !n_mreq) cnt++;
            pk = clkcpu;
        end
        chk("memwr_wait_samples", cnt, 2);
        @(negedge clk28);
        n_wait = 1'b1;
        wait_idle("memwr");

        // I/O read and I/O write
        d_i = 8'hBF;
        issue("iord", 3, 16'h00FE, 8'h00, 8'hBF, 0, 0, 1);
        req = 1'b0;
        wait_idle("iord");
        issue("iowr", 4, 16'h7FFE, 8'h5A, 8'h00, 0, 0, 1);
        req = 1'b0;
        wait_idle("iowr");

        // Handshake: a pulse while busy is dropped; held requests run back-to-back
        d_i = 8'h11;
        issue("memrd", 1, 16'h8000, 8'h00, 8'h11, 0, 0, 1);
        req = 1'b0;
        repeat (6) @(negedge clk28);
        chk("busy_not_ready", req_ready, 0);
        req_m1 = 1'b0; req_io = 1'b0; req_we = 1'b1; req_addr = 16'hC000; req = 1'b1;
        @(negedge clk28);
        req = 1'b0;
        wait_idle("memrd");
        repeat (40) @(negedge clk28);
        chk("pulse_ignored_addr", a, 16'h8000);
        issue("rd_a", 1, 16'h8001, 8'h00, 8'h11, 0, 0, 1);
        issue("rd_b", 1, 16'h8002, 8'h00, 8'h11, 0, 1, 1);
        req = 1'b0;
        wait_idle("held");

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
